// File: rtl/round_timer_if.sv
// Round timer bus: game controls in, phase status out.
// Clock and reset stay as plain ports on the timer.
interface round_timer_if #(
  parameter int CNT_W = 4,
  parameter int RND_W = 4
);
  logic             gameState;
  logic [CNT_W-1:0] roundTime;
  logic [CNT_W-1:0] restTime;
  logic [RND_W-1:0] numRounds;
  logic             cout;
  logic [CNT_W-1:0] sum;
  logic             tick;
  logic             phaseEnd;
  logic [RND_W-1:0] roundIdx;
  logic             gameDone;

  modport master (
    output gameState, roundTime, restTime, numRounds,
    input  cout, sum, tick, phaseEnd, roundIdx, gameDone
  );

  modport slave (
    input  gameState, roundTime, restTime, numRounds,
    output cout, sum, tick, phaseEnd, roundIdx, gameDone
  );
endinterface

// File: rtl/round_timer.sv
// Round timer: ACTIVE/REST phases counted in prescaled time units.
// Every output comes straight from a register.
module round_timer #(
  parameter int CNT_W    = 4,
  parameter int RND_W    = 4,
  parameter int PRESCALE = 4
) (
  input  logic         clk,
  input  logic         INIT,
  round_timer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACTIVE, REST, DONE} state_t;

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] sum_q, sum_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic             cout_q, cout_d;
  logic             tick_q, tick_d;
  logic             pe_q, pe_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] len_round;
  logic [CNT_W-1:0] len_rest;
  logic [RND_W-1:0] rnd_inc;

  // A zero length is stretched to one unit
  assign len_round = (bus.roundTime == '0) ? ONE : bus.roundTime;
  assign len_rest  = (bus.restTime == '0) ? ONE : bus.restTime;
  assign rnd_inc   = rnd_q + 1'b1;

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    sum_d   = sum_q;
    rnd_d   = rnd_q;
    cout_d  = cout_q;
    done_d  = done_q;
    tick_d  = 1'b0;
    pe_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.gameState) begin
          state_d = ACTIVE;
          sum_d   = len_round;
          presc_d = '0;
          cout_d  = 1'b1;
          pe_d    = 1'b1;
        end
      end
      ACTIVE, REST: begin
        if (bus.gameState) begin
          if (presc_q == PMAX) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (sum_q == ONE) begin
              pe_d = 1'b1;
              if (state_q == ACTIVE) begin
                rnd_d = rnd_inc;
                if (bus.numRounds != '0 &&
                    rnd_inc == bus.numRounds) begin
                  state_d = DONE;
                  sum_d   = '0;
                  cout_d  = 1'b0;
                  done_d  = 1'b1;
                end else if (bus.restTime == '0) begin
                  state_d = ACTIVE;
                  sum_d   = len_round;
                  cout_d  = 1'b1;
                end else begin
                  state_d = REST;
                  sum_d   = len_rest;
                  cout_d  = 1'b0;
                end
              end else begin
                state_d = ACTIVE;
                sum_d   = len_round;
                cout_d  = 1'b1;
              end
            end else begin
              sum_d = sum_q - ONE;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (!bus.gameState) begin
          state_d = IDLE;
          rnd_d   = '0;
          done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared by INIT
  always_ff @(posedge clk or posedge INIT) begin
    if (INIT) begin
      state_q <= IDLE;
      presc_q <= '0;
      sum_q   <= '0;
      rnd_q   <= '0;
      cout_q  <= 1'b0;
      tick_q  <= 1'b0;
      pe_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sum_q   <= sum_d;
      rnd_q   <= rnd_d;
      cout_q  <= cout_d;
      tick_q  <= tick_d;
      pe_q    <= pe_d;
      done_q  <= done_d;
    end
  end

  assign bus.cout     = cout_q;
  assign bus.sum      = sum_q;
  assign bus.tick     = tick_q;
  assign bus.phaseEnd = pe_q;
  assign bus.roundIdx = rnd_q;
  assign bus.gameDone = done_q;
endmodule

// File: tb/tb_round_timer.sv
// Directed bench for round_timer at CNT_W=4, RND_W=4, PRESCALE=4.
// Inputs change and outputs are sampled 1ns after the rising edge.
module tb_round_timer;
  logic clk = 1'b0;
  logic INIT;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  round_timer_if #(.CNT_W(4), .RND_W(4)) bus ();

  round_timer #(.CNT_W(4), .RND_W(4), .PRESCALE(4)) dut (
    .clk  (clk),
    .INIT (INIT),
    .bus  (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int act, rst_c, pe, tk, low, n;
  bit seen;

  initial begin
    INIT = 1'b1;
    bus.gameState = 1'b0;
    bus.roundTime = 4'd3;
    bus.restTime  = 4'd2;
    bus.numRounds = 4'd2;
    step(2);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_tick", bus.tick, 0);
    chk("rst_pe", bus.phaseEnd, 0);
    chk("rst_rnd", bus.roundIdx, 0);
    chk("rst_done", bus.gameDone, 0);
    INIT = 1'b0;
    step(3);
    chk("idle_cout", bus.cout, 0);
    chk("idle_sum", bus.sum, 0);

    // two-round game: 3 active, 2 rest
    bus.gameState = 1'b1;
    step(1);
    chk("start_pe", bus.phaseEnd, 1);
    chk("start_sum", bus.sum, 3);
    act = 0; rst_c = 0; pe = 0; tk = 0; seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.gameDone) begin
        seen = 1;
        break;
      end
      if (i == 4) chk("sum_i4", bus.sum, 2);
      if (i == 8) chk("sum_i8", bus.sum, 1);
      if (i == 12) begin
        chk("rest_sum", bus.sum, 2);
        chk("rest_cout", bus.cout, 0);
      end
      act   += int'(bus.cout);
      rst_c += int'(!bus.cout);
      pe    += int'(bus.phaseEnd);
      tk    += int'(bus.tick);
      step(1);
    end
    chk("done_seen", 32'(seen), 1);
    chk("act_cycles", act, 24);
    chk("rest_cycles", rst_c, 8);
    chk("ticks", tk, 7);
    pe += int'(bus.phaseEnd);
    chk("pe_total", pe, 4);
    chk("done_rnd", bus.roundIdx, 2);
    chk("done_sum", bus.sum, 0);
    chk("done_cout", bus.cout, 0);
    step(5);
    chk("done_hold", bus.gameDone, 1);
    chk("done_tick", bus.tick, 0);
    chk("done_hsum", bus.sum, 0);
    bus.gameState = 1'b0;
    step(1);
    chk("back_idle", bus.gameDone, 0);
    chk("idle_rnd", bus.roundIdx, 0);
    bus.gameState = 1'b1;
    step(1);
    chk("regame_cout", bus.cout, 1);
    chk("regame_sum", bus.sum, 3);

    // pause 10 cycles at sum=2, prescaler=2
    step(6);
    chk("pre_pause", bus.sum, 2);
    bus.gameState = 1'b0;
    tk = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      tk += int'(bus.tick);
    end
    chk("pause_tick", tk, 0);
    chk("pause_sum", bus.sum, 2);
    chk("pause_cout", bus.cout, 1);
    bus.gameState = 1'b1;
    step(1);
    chk("res1_sum", bus.sum, 2);
    chk("res1_tick", bus.tick, 0);
    step(1);
    chk("res2_sum", bus.sum, 1);
    chk("res2_tick", bus.tick, 1);

    // INIT in REST at sum=1
    step(8);
    chk("rest1_cout", bus.cout, 0);
    chk("rest1_sum", bus.sum, 1);
    INIT = 1'b1;
    #1;
    chk("init_sum", bus.sum, 0);
    chk("init_tick", bus.tick, 0);
    chk("init_rnd", bus.roundIdx, 0);
    step(1);
    chk("init_pe", bus.phaseEnd, 0);
    chk("init_cout", bus.cout, 0);
    INIT = 1'b0;
    step(1);
    chk("reent_cout", bus.cout, 1);
    chk("reent_sum", bus.sum, 3);

    // zero roundTime acts as one unit
    INIT = 1'b1;
    bus.roundTime = 4'd0;
    bus.restTime  = 4'd1;
    bus.numRounds = 4'd0;
    step(1);
    INIT = 1'b0;
    step(1);
    chk("z_sum", bus.sum, 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.cout) break;
      n++;
      step(1);
    end
    chk("z_len", n, 4);
    chk("z_rest", bus.sum, 1);

    // endless, no rest: roundIdx wraps
    INIT = 1'b1;
    bus.roundTime = 4'd2;
    bus.restTime  = 4'd0;
    step(1);
    INIT = 1'b0;
    step(1);
    low = 0; pe = 0;
    for (int i = 0; i <= 128; i++) begin
      if (i == 120) chk("wrap_15", bus.roundIdx, 15);
      if (i == 128) chk("wrap_0", bus.roundIdx, 0);
      low += int'(!bus.cout);
      if (i < 128) pe += int'(bus.phaseEnd);
      step(1);
    end
    chk("endless_cout", low, 0);
    chk("endless_pe", pe, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/round_timer.md
ROUND_TIMER -- requirements
Module: round_timer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4, meaning the phase-length and countdown width (minimum 2).
REQ-002 The block SHALL have parameter RND_W, default 4, meaning the round-counter width (minimum 1).
REQ-003 The block SHALL have parameter PRESCALE, default 4, meaning clock cycles per time unit (minimum 1).
REQ-004 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port INIT  input  1  reset, asynchronous and active-high.
REQ-006 The block SHALL have port gameState  input  1  run enable; 0 pauses the timer.
REQ-007 The block SHALL have port roundTime  input  CNT_W  active-phase length in time units, sampled at each ACTIVE load.
REQ-008 The block SHALL have port restTime  input  CNT_W  rest-phase length in time units, sampled at each REST load.
REQ-009 The block SHALL have port numRounds  input  RND_W  rounds per game; 0 means endless.
REQ-010 The block SHALL have port cout  output  1  high while in ACTIVE.
REQ-011 The block SHALL have port sum  output  CNT_W  time units remaining in the current phase.
REQ-012 The block SHALL have port tick  output  1  one-cycle pulse per elapsed time unit.
REQ-013 The block SHALL have port phaseEnd  output  1  one-cycle pulse in the first cycle of a new phase or of DONE.
REQ-014 The block SHALL have port roundIdx  output  RND_W  count of completed ACTIVE phases.
REQ-015 The block SHALL have port gameDone  output  1  high while in DONE.

Function
REQ-016 All outputs SHALL be driven directly from registers.
REQ-017 The state machine SHALL have states IDLE, ACTIVE, REST, DONE.
REQ-018 "Running" SHALL mean state is ACTIVE or REST and gameState=1.
REQ-019 The prescaler SHALL count 0..PRESCALE-1 only while running, wrapping to 0.
REQ-020 On the edge where running and prescaler=PRESCALE-1, tick SHALL be 1 for the following cycle and sum SHALL decrement by 1 in the same cycle.
REQ-021 With PRESCALE=1, tick SHALL assert on every running cycle.
REQ-022 When gameState=0 in ACTIVE or REST, prescaler, sum, state and roundIdx SHALL hold, and tick SHALL stay 0.
REQ-023 In IDLE, gameState=1 sampled at an edge SHALL enter ACTIVE at that edge, with sum=roundTime, prescaler=0 and cout=1.
REQ-024 Any load of a 0 length SHALL be treated as 1, so sum loads 1 when roundTime or restTime is 0.
REQ-025 A tick with sum=1 SHALL end the phase: sum reloads instead of reaching 0 and the prescaler clears.
REQ-026 At the end of ACTIVE, roundIdx SHALL increment (wrapping mod 2^RND_W).
REQ-027 At the end of ACTIVE, if numRounds≠0 and the incremented roundIdx equals numRounds, the next state SHALL be DONE.
REQ-028 At the end of ACTIVE, if DONE is not entered and restTime=0, the next state SHALL be ACTIVE again (rest skipped) with sum=roundTime.
REQ-029 At the end of ACTIVE, if DONE is not entered and restTime≠0, the next state SHALL be REST with sum=restTime.
REQ-030 At the end of REST, the next state SHALL be ACTIVE with sum=roundTime.
REQ-031 phaseEnd SHALL be 1 for exactly the one cycle following each phase end, coincident with tick.
REQ-032 In DONE, the block SHALL hold sum=0, cout=0, gameDone=1 and tick=0.
REQ-033 DONE SHALL return to IDLE when gameState=0 is sampled, clearing roundIdx.
REQ-034 In IDLE, the block SHALL hold sum=0, cout=0, gameDone=0 and roundIdx=0.
REQ-035 Changes to roundTime or restTime mid-phase SHALL have no effect until the next load.
REQ-036 A change to numRounds SHALL take effect at the next ACTIVE end.

Reset
REQ-037 INIT=1 SHALL asynchronously force: state=IDLE, prescaler=0, sum=0, cout=0, tick=0, phaseEnd=0, roundIdx=0, gameDone=0.
REQ-038 INIT asserted at any point, including mid-phase and in DONE, SHALL abandon the game, and no pulse SHALL be emitted.
REQ-039 After INIT deasserts, the block SHALL stay in IDLE until gameState=1 is sampled.

Verification (defaults: CNT_W=4, RND_W=4, PRESCALE=4)
REQ-040 Scenario: roundTime=3, restTime=2, numRounds=2, gameState=1 -> ACTIVE 12 cycles (sum 3,2,1), REST 8 cycles (sum 2,1), ACTIVE 12 cycles, then DONE with gameDone=1, roundIdx=2, sum=0, and 4 phaseEnd pulses in total.
REQ-041 Scenario: pause, with gameState dropped for 10 cycles mid-ACTIVE at sum=2 -> sum, prescaler and cout frozen, no tick; after resume, the remaining time is unchanged (phase completes 10 cycles late).
REQ-042 Scenario: restTime=0, roundTime=2, numRounds=0 -> ACTIVE back-to-back every 8 cycles, cout constantly 1, roundIdx increments 0..15 then wraps to 0.
REQ-043 Scenario: roundTime=0 -> ACTIVE lasts exactly 4 cycles with sum=1.
REQ-044 Scenario: INIT pulsed while in REST with sum=1 -> immediately IDLE, all outputs 0; with gameState held 1, ACTIVE is re-entered at the first edge after INIT deasserts with sum=roundTime.
REQ-045 Scenario: in DONE, gameState held 1 -> the block stays in DONE; gameState=0 for 1 cycle -> IDLE with roundIdx=0; gameState=1 again -> a new game starts.
